// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM encoding and one-hot helper
// for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int HOLD_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [IDX_W-1:0] idx
  );
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters and arbiter.
// master: drives req; slave: drives gnt/gnt_idx/gnt_vld/expired.
interface rr_arbiter_8_if
  import rr_arb_pkg::*;
();

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic               expired;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld,
    input  expired
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_vld,
    output expired
  );

endinterface

// File: rtl/rr_prio_pick.sv
// Circular priority search: first set req bit at or above ptr.
// Ports: req (in), ptr (in), any (out), idx (out).
module rr_prio_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with per-tenure hold limit.
// Ports: clk, rst (sync, active-high), bus (slave modport).
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter_8_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               vld_q, vld_d;
  logic               exp_q, exp_d;

  logic [IDX_W-1:0]   base;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic               held;
  logic               at_limit;

  // While granting, search from the slot after the owner:
  // this is the post-release ptr, and the owner itself is
  // reached last so a lone expiring requester is re-granted.
  assign base = (state_q == GRANT) ?
                (idx_q + IDX_W'(1)) : ptr_q;

  rr_prio_pick u_pick (
    .req (bus.req),
    .ptr (base),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign held     = bus.req[idx_q];
  assign at_limit = (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    vld_d   = vld_q;
    exp_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          idx_d   = pick_idx;
          hold_d  = '0;
          vld_d   = 1'b1;
        end
      end
      GRANT: begin
        if (held && !at_limit) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          ptr_d = idx_q + IDX_W'(1);
          exp_d = held;
          if (pick_any) begin
            idx_d  = pick_idx;
            hold_d = '0;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
            vld_d   = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = vld_d ? onehot(idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = vld_q;
  assign bus.expired = exp_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: vector table plus
// hand sequences for hold expiry and MAX_HOLD = 1 rotation.
module tb_rr_arbiter_8;
  import rr_arb_pkg::*;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_r = 1'b1;
  logic [7:0] req_r = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[$];

  rr_arbiter_8_if bus4 ();
  rr_arbiter_8_if bus1 ();

  assign bus4.req = req_r;
  assign bus1.req = req_r;

  rr_arbiter_8 #(.MAX_HOLD(4)) u4 (
    .clk (clk),
    .rst (rst_r),
    .bus (bus4)
  );

  rr_arbiter_8 #(.MAX_HOLD(1)) u1 (
    .clk (clk),
    .rst (rst_r),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic r, input logic [7:0] q);
    rst_r = r;
    req_r = q;
    @(posedge clk);
    #1;
  endtask

  // idx is only meaningful while a grant is valid.
  task automatic chk(
    input string      nm,
    input logic [7:0] ag, input logic [2:0] ai,
    input logic       av, input logic       ae,
    input logic [7:0] eg, input logic [2:0] ei,
    input logic       ev, input logic       ee
  );
    logic [12:0] a, e;
    a = {ag, ev ? ai : 3'd0, av, ae};
    e = {eg, ev ? ei : 3'd0, ev, ee};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got gnt=%h idx=%0d vld=%b exp=%b, want gnt=%h idx=%0d vld=%b exp=%b",
               nm, ag, ai, av, ae, eg, ei, ev, ee);
    end
  endtask

  task automatic chk4(
    input string nm, input logic [2:0] ei,
    input logic ev, input logic ee
  );
    chk(nm, bus4.gnt, bus4.gnt_idx, bus4.gnt_vld,
        bus4.expired, ev ? onehot(ei) : 8'h00, ei, ev, ee);
  endtask

  task automatic chk1(
    input string nm, input logic [2:0] ei,
    input logic ev, input logic ee
  );
    chk(nm, bus1.gnt, bus1.gnt_idx, bus1.gnt_vld,
        bus1.expired, ev ? onehot(ei) : 8'h00, ei, ev, ee);
  endtask

  task automatic add(
    input logic r, input logic [7:0] q,
    input logic [7:0] g, input logic [2:0] i,
    input logic v, input logic e, input string nm
  );
    vec_t t;
    t.rst = r; t.req = q; t.gnt = g; t.idx = i;
    t.vld = v; t.exp = e; t.name = nm;
    vecs.push_back(t);
  endtask

  initial begin
    // idle after reset
    add(1, 8'h00, 8'h00, 0, 0, 0, "rst_state");
    for (int k = 0; k < 5; k++)
      add(0, 8'h00, 8'h00, 0, 0, 0, "idle_noreq");
    // 0 then 7, no idle gap; ptr wraps 7->0
    add(1, 8'h00, 8'h00, 0, 0, 0, "rst_b");
    add(0, 8'h81, 8'h01, 0, 1, 0, "first_g0");
    add(0, 8'h81, 8'h01, 0, 1, 0, "hold_g0");
    add(0, 8'h80, 8'h80, 7, 1, 0, "hand_to_7");
    add(0, 8'h00, 8'h00, 0, 0, 0, "vol_to_idle");
    add(0, 8'h02, 8'h02, 1, 1, 0, "wrap_ptr_g1");
    // other requesters toggling do not disturb owner 3
    add(1, 8'h00, 8'h00, 0, 0, 0, "rst_e");
    add(0, 8'h08, 8'h08, 3, 1, 0, "g3");
    add(0, 8'h28, 8'h08, 3, 1, 0, "g3_r5");
    add(0, 8'h0A, 8'h08, 3, 1, 0, "g3_r1");
    add(0, 8'h2A, 8'h08, 3, 1, 0, "g3_r51");
    add(0, 8'h22, 8'h20, 5, 1, 0, "drop3_g5");
    // reset mid-tenure, then ptr back to 0
    add(1, 8'h00, 8'h00, 0, 0, 0, "rst_f");
    add(0, 8'h30, 8'h10, 4, 1, 0, "g4");
    add(0, 8'h30, 8'h10, 4, 1, 0, "g4_hold");
    add(0, 8'h10, 8'h10, 4, 1, 0, "g4_hold2");
    add(0, 8'h30, 8'h10, 4, 1, 0, "g4_hold3");
    add(1, 8'h30, 8'h00, 0, 0, 0, "rst_mid");
    add(0, 8'h30, 8'h10, 4, 1, 0, "post_rst_g4");

    foreach (vecs[n]) begin
      tick(vecs[n].rst, vecs[n].req);
      chk(vecs[n].name, bus4.gnt, bus4.gnt_idx,
          bus4.gnt_vld, bus4.expired, vecs[n].gnt,
          vecs[n].idx, vecs[n].vld, vecs[n].exp);
    end

    // all request, MAX_HOLD=4: 4-cycle tenures rotating
    tick(1, 8'h00);
    for (int k = 0; k < 36; k++) begin
      tick(0, 8'hFF);
      chk4("rot_ff", 3'((k / 4) % 8), 1'b1,
           (k > 0) && (k % 4 == 0));
    end

    // lone requester 2 re-granted on each expiry
    tick(1, 8'h00);
    for (int k = 0; k < 12; k++) begin
      tick(0, 8'h04);
      chk4("lone_r2", 3'd2, 1'b1,
           (k > 0) && (k % 4 == 0));
    end

    // MAX_HOLD=1: rotate every cycle
    tick(1, 8'h00);
    for (int k = 0; k < 10; k++) begin
      tick(0, 8'hFF);
      chk1("mh1_rot", 3'(k % 8), 1'b1, k > 0);
    end
    tick(0, 8'h00);
    chk1("mh1_idle", 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
